dcache_assoc: RTL and testbench
===============================

// Module: dcache_assoc
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache between the
//  datapath memory port and the memory arbiter. Serves hits in the request cycle and fills
//  or evicts multi-word blocks over the dwait handshake. On halt it flushes every dirty block,
//  writes the hit count to HITCNT_ADDR and raises flushed. Uses cpu_types_pkg::word_t (32 b).
// PARAMETERS
//  SETS        8        number of sets, power of 2, >=2
//  WAYS        2        associativity, one of 1/2/4
//  BLKWORDS    2        words per block, power of 2, >=1
//  HITCNT_ADDR 32'h3100 address written with the hit count at the end of the flush
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   synchronous reset, active-high
//  dmemREN    in   1   datapath read request
//  dmemWEN    in   1   datapath write request; wins if asserted together with dmemREN
//  dmemaddr   in   32  byte address, word aligned ([1:0] ignored)
//  dmemstore  in   32  write data
//  halt       in   1   datapath halted; starts the flush
//  dhit       out  1   request serviced this cycle (combinational)
//  dmemload   out  32  read data, valid while dhit
//  flushed    out  1   flush complete; stays high until RST
//  dREN       out  1   memory read request
//  dWEN       out  1   memory write request
//  daddr      out  32  memory word address
//  dstore     out  32  memory write data
//  dload      in   32  memory read data, valid when dwait low
//  dwait      in   1   memory busy; a transfer completes in the cycle dREN|dWEN is high and dwait is low
// BEHAVIOUR
//  Address split: [1:0] byte, next log2(BLKWORDS) bits word offset, next log2(SETS) bits index,
//   remaining bits tag. Each way holds valid, dirty, tag and BLKWORDS data words.
//   Each set holds a victim pointer of log2(WAYS) bits.
//  Reset: all valid, dirty and victim pointers = 0; hit counter = 0; state = IDLE.
//   dhit, flushed, dREN, dWEN = 0; daddr, dstore, dmemload = 0.
//   Reset asserted mid-miss or mid-flush aborts the operation; memory strobes drop on the next edge.
//  IDLE: a request hits when a valid way in the indexed set has a matching tag.
//   Hit, 0-cycle latency: dhit=1 and read data is returned in the same cycle.
//   A write hit stores dmemstore and sets dirty at the edge. Each hit cycle increments the hit counter once.
//  IDLE miss: the victim is the lowest-numbered invalid way; if none, the way named by the victim pointer.
//   If the victim is valid and dirty -> WB, otherwise -> FETCH. dhit stays 0 throughout.
//  WB: writes the victim's BLKWORDS words to {victim tag, index, word k, 2'b00} for k = 0..N-1.
//   k advances on each dwait-low cycle; after the last word -> FETCH.
//  FETCH: reads the requested block's words k = 0..N-1 from memory into the victim way.
//   After the last word: valid=1, dirty=0, tag updated, victim pointer = (victim+1) mod WAYS.
//   Then -> IDLE, where the request re-evaluates as a hit.
//  halt: sampled only in IDLE, where it has priority over a new request.
//   A miss in progress completes first. While halted, dhit=0.
//  FLUSH: scans all sets and ways in index-major, way-minor order.
//   Each valid+dirty block is written back as in WB; clean or invalid entries take 1 cycle each.
//   After the scan -> HITCNT: dWEN=1, daddr=HITCNT_ADDR, dstore=hit counter, held until dwait low.
//   Then -> DONE: flushed=1, all memory strobes 0, no further requests serviced.
//  Memory side: dREN and dWEN are never high together. daddr and dstore are held stable while dwait=1.
//  Hit counter is 32 bits and wraps modulo 2^32.
// TESTING
//  1. RST, then read 0x40 with dwait=1 for 2 cycles per word -> two reads, 0x40 and 0x44; then dhit=1 with dload data.
//  2. Write 0xDEADBEEF to 0x40, then read 0x40 -> dhit same cycle, dmemload=0xDEADBEEF, no memory traffic.
//  3. SETS=8, WAYS=2, BLKWORDS=2: dirty 0x40 and 0x80, then read 0xC0 -> WB of the 0x40 block, then FETCH of 0xC0.
//  4. halt with 2 dirty blocks after 5 hits -> 4 memory writes, then write of 5 to 0x3100, then flushed=1.
//  5. RST asserted during FETCH word 1 -> next cycle dREN=0, state IDLE; the re-request misses again.
//  6. dmemREN and dmemWEN both high on a hit -> write performed, dirty set, hit counter +1.

Source files
------------

// File: rtl/dcache_assoc_if.sv
// Datapath-side and memory-side signals of the data cache. The datapath and memory
// environment drive through master; the cache connects through slave.
interface dcache_assoc_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with halt-time flush.
// Hits complete in the request cycle; misses and the flush stall on dwait one word at a time.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

module dcache_assoc
    import cpu_types_pkg::*;
#(
    parameter int          SETS        = 8,
    parameter int          WAYS        = 2,
    parameter int          BLKWORDS    = 2,
    parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
    input  logic           CLK,
    input  logic           RST,
    dcache_assoc_if.slave  bus
);
    localparam int OW = $clog2(BLKWORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - OW - IW;
    localparam int KW = (OW > 0) ? OW : 1;
    localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BLKWORDS - 1);
    localparam logic [VW-1:0] W_LAST = VW'(WAYS - 1);
    localparam logic [IW-1:0] S_LAST = IW'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, HITCNT, DONE} state_t;

    state_t state, nstate;

    logic          valid_q [SETS][WAYS];
    logic          dirty_q [SETS][WAYS];
    logic [TW-1:0] tag_q   [SETS][WAYS];
    word_t         data_q  [SETS][WAYS][BLKWORDS];
    logic [VW-1:0] vptr_q  [SETS];

    word_t         hitcnt_q;
    logic [KW-1:0] k_q;
    logic [VW-1:0] vic_q;
    logic [IW-1:0] mi_q;
    logic [TW-1:0] mt_q;
    logic [IW-1:0] fs_q;
    logic [VW-1:0] fw_q;

    logic [29:0]   wa;
    logic [IW-1:0] r_idx;
    logic [KW-1:0] r_off;
    logic [TW-1:0] r_tag;
    logic          unused_bits;

    assign wa          = bus.dmemaddr[31:2];
    assign r_idx       = IW'(wa >> OW);
    assign r_off       = KW'(wa & 30'(BLKWORDS - 1));
    assign r_tag       = TW'(wa >> (OW + IW));
    assign unused_bits = ^bus.dmemaddr[1:0];

    function automatic word_t mk_addr(input logic [TW-1:0] t, input logic [IW-1:0] s,
                                      input logic [KW-1:0] k);
        logic [29:0] w;
        w = (30'(t) << (OW + IW)) | (30'(s) << OW) | 30'(k);
        return {w, 2'b00};
    endfunction

    logic          hit;
    logic [VW-1:0] hit_way;
    logic [VW-1:0] vic_sel;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[r_idx][w] && tag_q[r_idx][w] == r_tag) begin
                hit     = 1'b1;
                hit_way = VW'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way is the one left standing.
    always_comb begin
        vic_sel = vptr_q[r_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[r_idx][w]) vic_sel = VW'(w);
        end
    end

    logic req, serve, fl_dirty, fl_step, k_last;

    assign req      = bus.dmemREN | bus.dmemWEN;
    assign serve    = (state == IDLE) && !bus.halt && req && hit;
    assign fl_dirty = valid_q[fs_q][fw_q] && dirty_q[fs_q][fw_q];
    assign k_last   = (k_q == K_LAST);
    assign fl_step  = !fl_dirty || (!bus.dwait && k_last);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (bus.halt)
                    nstate = FLUSH;
                else if (req && !hit)
                    nstate = (valid_q[r_idx][vic_sel] && dirty_q[r_idx][vic_sel]) ? WB : FETCH;
            end
            WB:     if (!bus.dwait && k_last) nstate = FETCH;
            FETCH:  if (!bus.dwait && k_last) nstate = IDLE;
            FLUSH:  if (fl_step && fw_q == W_LAST && fs_q == S_LAST) nstate = HITCNT;
            HITCNT: if (!bus.dwait) nstate = DONE;
            DONE:   nstate = DONE;
            default: nstate = IDLE;
        endcase
    end

    logic  dhit, flushed, dren, dwen;
    word_t dmemload, daddr, dstore;

    always_comb begin
        dhit     = 1'b0;
        flushed  = 1'b0;
        dren     = 1'b0;
        dwen     = 1'b0;
        dmemload = '0;
        daddr    = '0;
        dstore   = '0;
        case (state)
            IDLE: begin
                dhit     = serve;
                dmemload = serve ? data_q[r_idx][hit_way][r_off] : '0;
            end
            WB: begin
                dwen   = 1'b1;
                daddr  = mk_addr(tag_q[mi_q][vic_q], mi_q, k_q);
                dstore = data_q[mi_q][vic_q][k_q];
            end
            FETCH: begin
                dren  = 1'b1;
                daddr = mk_addr(mt_q, mi_q, k_q);
            end
            FLUSH: begin
                if (fl_dirty) begin
                    dwen   = 1'b1;
                    daddr  = mk_addr(tag_q[fs_q][fw_q], fs_q, k_q);
                    dstore = data_q[fs_q][fw_q][k_q];
                end
            end
            HITCNT: begin
                dwen   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hitcnt_q;
            end
            DONE:    flushed = 1'b1;
            default: ;
        endcase
    end

    assign bus.dhit     = dhit;
    assign bus.flushed  = flushed;
    assign bus.dREN     = dren;
    assign bus.dWEN     = dwen;
    assign bus.dmemload = dmemload;
    assign bus.daddr    = daddr;
    assign bus.dstore   = dstore;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hitcnt_q <= '0;
            k_q      <= '0;
            vic_q    <= '0;
            mi_q     <= '0;
            mt_q     <= '0;
            fs_q     <= '0;
            fw_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                vptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            if (serve) hitcnt_q <= hitcnt_q + 32'd1;
            if (serve && bus.dmemWEN) dirty_q[r_idx][hit_way] <= 1'b1;
            case (state)
                IDLE: begin
                    k_q <= '0;
                    if (bus.halt) begin
                        fs_q <= '0;
                        fw_q <= '0;
                    end else if (req && !hit) begin
                        vic_q <= vic_sel;
                        mi_q  <= r_idx;
                        mt_q  <= r_tag;
                    end
                end
                WB: begin
                    if (!bus.dwait) k_q <= k_last ? '0 : k_q + 1'b1;
                end
                FETCH: begin
                    if (!bus.dwait) begin
                        k_q <= k_last ? '0 : k_q + 1'b1;
                        if (k_last) begin
                            valid_q[mi_q][vic_q] <= 1'b1;
                            dirty_q[mi_q][vic_q] <= 1'b0;
                            tag_q[mi_q][vic_q]   <= mt_q;
                            vptr_q[mi_q]         <= (vic_q == W_LAST) ? '0 : vic_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (fl_dirty && !bus.dwait) begin
                        k_q <= k_last ? '0 : k_q + 1'b1;
                        if (k_last) dirty_q[fs_q][fw_q] <= 1'b0;
                    end
                    if (fl_step) begin
                        if (fw_q == W_LAST) begin
                            fw_q <= '0;
                            fs_q <= fs_q + 1'b1;
                        end else begin
                            fw_q <= fw_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Block data carries no reset; valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (serve && bus.dmemWEN)
                data_q[r_idx][hit_way][r_off] <= bus.dmemstore;
            if (state == FETCH && !bus.dwait)
                data_q[mi_q][vic_q][k_q] <= bus.dload;
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: miss fill, write hit, writeback eviction, flush with hit
// count, reset mid-fetch and simultaneous read/write, against a small latency memory model.
module tb_dcache_assoc;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dcache_assoc_if bus ();

    dcache_assoc #(
        .SETS(8), .WAYS(2), .BLKWORDS(2), .HITCNT_ADDR(32'h3100)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [31:0] log_w[$];
    bit          both_seen = 1'b0;
    int          cnt;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory: each word holds dwait high for two cycles, then completes.
    initial begin
        bus.dwait = 1'b1;
        bus.dload = '0;
        cnt = 0;
        forever begin
            @(negedge CLK);
            if (bus.dREN && bus.dWEN) both_seen = 1'b1;
            if ((bus.dREN || bus.dWEN) && !RST) begin
                if (cnt < 2) begin
                    bus.dwait = 1'b1;
                    cnt++;
                end else begin
                    bus.dwait = 1'b0;
                    cnt = 0;
                    log_a.push_back(bus.daddr);
                    log_w.push_back({31'd0, bus.dWEN});
                    if (bus.dWEN) begin
                        mem[bus.daddr] = bus.dstore;
                        log_d.push_back(bus.dstore);
                    end else begin
                        bus.dload = mem_rd(bus.daddr);
                        log_d.push_back(bus.dload);
                    end
                end
            end else begin
                bus.dwait = 1'b1;
                cnt = 0;
            end
        end
    end

    task automatic chk_log(input string tag, input int i, input logic [31:0] w,
                           input logic [31:0] a, input logic [31:0] d);
        check({tag, "_addr"}, (i < log_a.size()) ? log_a[i] : 32'hFFFF_FFFF, a);
        check({tag, "_we"},   (i < log_w.size()) ? log_w[i] : 32'hFFFF_FFFF, w);
        check({tag, "_data"}, (i < log_d.size()) ? log_d[i] : 32'hFFFF_FFFF, d);
    endtask

    task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
        lat = -1;
        rd  = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bus.dhit) begin
                rd  = bus.dmemload;
                lat = i;
                break;
            end
        end
        if (lat < 0) check("access_timeout", 32'(lat), 32'd0);
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        bus.halt = 1'b0;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic do_flush();
        int n;
        bus.halt = 1'b1;
        n = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (bus.flushed) begin
                n = i;
                break;
            end
        end
        if (n < 0) check("flush_timeout", 32'(n), 32'd0);
        check("flushed", {31'd0, bus.flushed}, 32'd1);
        check("done_strobes", {30'd0, bus.dREN, bus.dWEN}, 32'd0);
    endtask

    logic [31:0] rd;
    int          lat;
    int          n0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        bus.halt = 1'b0;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.dmemaddr = '0;
        bus.dmemstore = '0;
        do_reset();

        @(negedge CLK);
        check("rst_dhit",     {31'd0, bus.dhit},    32'd0);
        check("rst_flushed",  {31'd0, bus.flushed}, 32'd0);
        check("rst_strobes",  {30'd0, bus.dREN, bus.dWEN}, 32'd0);
        check("rst_daddr",    bus.daddr,    32'd0);
        check("rst_dstore",   bus.dstore,   32'd0);
        check("rst_dmemload", bus.dmemload, 32'd0);
        @(posedge CLK);
        #1;

        // Cold read miss: fetch of two words, then the hit.
        access(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        check("t1_lat", 32'(lat), 32'd7);
        check("t1_data", rd, 32'h5A5A_0040);
        check("t1_nlog", 32'(log_a.size()), 32'd2);
        chk_log("t1_w0", 0, 32'd0, 32'h40, 32'h5A5A_0040);
        chk_log("t1_w1", 1, 32'd0, 32'h44, 32'h5A5A_0044);

        // Write hit then read hit, both in the request cycle.
        access(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, rd, lat);
        check("t2_wlat", 32'(lat), 32'd0);
        access(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        check("t2_rlat", 32'(lat), 32'd0);
        check("t2_data", rd, 32'hDEAD_BEEF);
        check("t2_nlog", 32'(log_a.size()), 32'd2);

        // Fill way 1 with 0x80 (dirty), then 0xC0 evicts the dirty 0x40 block.
        access(1'b0, 1'b1, 32'h80, 32'h1111_2222, rd, lat);
        check("t3_wlat", 32'(lat), 32'd7);
        n0 = log_a.size();
        access(1'b1, 1'b0, 32'hC0, 32'h0, rd, lat);
        check("t3_lat", 32'(lat), 32'd13);
        check("t3_data", rd, 32'h5A5A_00C0);
        check("t3_nlog", 32'(log_a.size() - n0), 32'd4);
        chk_log("t3_wb0", n0,     32'd1, 32'h40, 32'hDEAD_BEEF);
        chk_log("t3_wb1", n0 + 1, 32'd1, 32'h44, 32'h5A5A_0044);
        chk_log("t3_f0",  n0 + 2, 32'd0, 32'hC0, 32'h5A5A_00C0);
        chk_log("t3_f1",  n0 + 3, 32'd0, 32'hC4, 32'h5A5A_00C4);

        // Read and write together on a hit: the write wins.
        n0 = log_a.size();
        access(1'b1, 1'b1, 32'hC4, 32'h0C4C_0C4C, rd, lat);
        check("t6_lat", 32'(lat), 32'd0);
        access(1'b1, 1'b0, 32'hC4, 32'h0, rd, lat);
        check("t6_data", rd, 32'h0C4C_0C4C);
        check("t6_nlog", 32'(log_a.size() - n0), 32'd0);

        // Flush: way 0 (0xC0 block) then way 1 (0x80 block), then hit count of 7.
        n0 = log_a.size();
        do_flush();
        check("fl1_nlog", 32'(log_a.size() - n0), 32'd5);
        chk_log("fl1_0", n0,     32'd1, 32'hC0,   32'h5A5A_00C0);
        chk_log("fl1_1", n0 + 1, 32'd1, 32'hC4,   32'h0C4C_0C4C);
        chk_log("fl1_2", n0 + 2, 32'd1, 32'h80,   32'h1111_2222);
        chk_log("fl1_3", n0 + 3, 32'd1, 32'h84,   32'h5A5A_0084);
        chk_log("fl1_h", n0 + 4, 32'd1, 32'h3100, 32'd7);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h40;
        @(negedge CLK);
        @(negedge CLK);
        check("done_nohit", {31'd0, bus.dhit}, 32'd0);

        // Reset during the second fetch word aborts the miss.
        do_reset();
        @(negedge CLK);
        check("t5_flushed_clr", {31'd0, bus.flushed}, 32'd0);
        @(posedge CLK);
        #1;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h48;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.dREN && bus.daddr == 32'h4C) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("t5_word1_timeout", 32'(lat), 32'd0);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("t5_dren_drop", {31'd0, bus.dREN}, 32'd0);
        check("t5_dhit", {31'd0, bus.dhit}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n0 = log_a.size();
        access(1'b1, 1'b0, 32'h48, 32'h0, rd, lat);
        check("t5_relat", 32'(lat), 32'd7);
        check("t5_data", rd, 32'h5A5A_0048);
        chk_log("t5_f0", n0,     32'd0, 32'h48, 32'h5A5A_0048);
        chk_log("t5_f1", n0 + 1, 32'd0, 32'h4C, 32'h5A5A_004C);

        // Five hits, two dirty blocks, then flush.
        do_reset();
        access(1'b0, 1'b1, 32'h40, 32'hA0A0_A0A0, rd, lat);
        access(1'b0, 1'b1, 32'h80, 32'hB0B0_B0B0, rd, lat);
        access(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        check("t4_r40", rd, 32'hA0A0_A0A0);
        access(1'b1, 1'b0, 32'h80, 32'h0, rd, lat);
        check("t4_r80", rd, 32'hB0B0_B0B0);
        access(1'b1, 1'b0, 32'h44, 32'h0, rd, lat);
        check("t4_r44", rd, 32'h5A5A_0044);
        n0 = log_a.size();
        do_flush();
        check("t4_nlog", 32'(log_a.size() - n0), 32'd5);
        chk_log("t4_0", n0,     32'd1, 32'h40,   32'hA0A0_A0A0);
        chk_log("t4_1", n0 + 1, 32'd1, 32'h44,   32'h5A5A_0044);
        chk_log("t4_2", n0 + 2, 32'd1, 32'h80,   32'hB0B0_B0B0);
        chk_log("t4_3", n0 + 3, 32'd1, 32'h84,   32'h5A5A_0084);
        chk_log("t4_h", n0 + 4, 32'd1, 32'h3100, 32'd5);

        check("excl_strobes", {31'd0, both_seen}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
